// File: rtl/ps2_decoder_pkg.sv
// Shared constants, state encodings and frame check for the PS/2 keyboard receiver.
package ps2_decoder_pkg;

  localparam int FRAME_BITS = 11;
  localparam int UART_BITS  = 10;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

  localparam int UO_VALID = 0;
  localparam int UO_INT   = 1;
  localparam int UO_RDY   = 2;
  localparam int UO_FULL  = 3;
  localparam int UO_TX    = 4;

  // Good frame: start low, stop high, odd ones count over data plus parity.
  function automatic logic frame_ok(input logic start, input logic [7:0] data,
                                    input logic par, input logic stop);
    return !start && stop && (^{data, par});
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the PS/2 lines, samples on clock falls,
// checks framing/parity and emits one-cycle good/bad strobes with the byte.
module ps2_rx_frame
  import ps2_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_data,
  output logic       o_good,
  output logic       o_bad,
  output logic [1:0] o_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  // valid/ready is not used here: o_good/o_bad are single-cycle strobes the
  // consumer must act on immediately; o_data is stable while either is high.
  logic            r_clk_meta, r_clk_sync, r_clk_prev;
  logic            r_data_meta, r_data_sync;
  rx_state_t       r_state, w_next;
  logic [3:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_start, r_parity;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_fall, w_timeout, w_done, w_ok;

  // Lines idle high, so the synchronisers reset high to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= i_ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= i_ps2_data;
      r_data_sync <= r_data_meta;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_sync;
  assign w_timeout = (r_state != IDLE) && !w_fall &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_next = DATA;
      DATA:    if (w_timeout) w_next = IDLE;
               else if (w_fall && r_bit_cnt == 4'(FRAME_BITS - 3)) w_next = PARITY;
      PARITY:  if (w_timeout) w_next = IDLE;
               else if (w_fall) w_next = STOP;
      STOP:    if (w_timeout || w_fall) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_start   <= 1'b0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (r_state == IDLE || w_fall || w_timeout) r_to_cnt <= '0;
      else                                         r_to_cnt <= r_to_cnt + 1'b1;
      if (w_fall) begin
        case (r_state)
          IDLE: begin
            r_start   <= r_data_sync;
            r_bit_cnt <= 4'd1;
          end
          DATA: begin
            r_shift   <= {r_data_sync, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
          PARITY: begin
            r_parity  <= r_data_sync;
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // The stop bit is judged straight off the synchroniser on its own fall.
  always_comb begin
    w_done  = (r_state == STOP) && w_fall;
    w_ok    = frame_ok(r_start, r_shift, r_parity, r_data_sync);
    o_good  = w_done && w_ok;
    o_bad   = w_done && !w_ok;
    o_data  = r_shift;
    o_state = r_state;
  end

endmodule

// File: rtl/ps2_decoder.sv
// PS/2 keyboard decoder in Tiny Tapeout pin form: scancode FIFO read by the
// host via chip select, arrival interrupt and an 8N1 UART echo of good bytes.
module ps2_decoder
  import ps2_decoder_pkg::*;
#(
  parameter int CLK_HZ         = 10_000_000,
  parameter int BAUD           = 115200,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

  logic [7:0]       w_rx_data;
  logic             w_good, w_bad;
  logic [1:0]       w_rx_state;
  logic             w_unused;

  logic             r_clr_meta, r_clr_sync, r_cs_meta, r_cs_sync, r_cs_prev;
  logic             w_cs_fall;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_empty, w_full, w_push, w_pop;
  logic             r_valid, r_int;

  uart_state_t      r_u_state, w_u_next;
  logic [BAUD_W-1:0] r_baud;
  logic [3:0]       r_u_bits;
  logic [7:0]       r_tx_shift;
  logic             w_bit_end, w_load, w_tx;

  assign w_unused = ^{ena, uio_in, ui_in[7:4], w_rx_state};

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .i_ps2_clk  (ui_in[0]),
    .i_ps2_data (ui_in[1]),
    .o_data     (w_rx_data),
    .o_good     (w_good),
    .o_bad      (w_bad),
    .o_state    (w_rx_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_meta <= 1'b0;
      r_clr_sync <= 1'b0;
      r_cs_meta  <= 1'b0;
      r_cs_sync  <= 1'b0;
      r_cs_prev  <= 1'b0;
    end else begin
      r_clr_meta <= ui_in[2];
      r_clr_sync <= r_clr_meta;
      r_cs_meta  <= ui_in[3];
      r_cs_sync  <= r_cs_meta;
      r_cs_prev  <= r_cs_sync;
    end
  end

  // The host read ends on cs falling; that is when the head is consumed.
  assign w_cs_fall = r_cs_prev & ~r_cs_sync;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push    = w_good & ~w_full;
  assign w_pop     = w_cs_fall & ~w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_int    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_good)     r_valid <= 1'b1;
      else if (w_bad) r_valid <= 1'b0;
      if (w_push)          r_int <= 1'b1;
      else if (r_clr_sync) r_int <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rx_data;
  end

  // UART echo: a good byte is only taken when the transmitter is idle.
  assign w_bit_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_load    = w_good && (r_u_state == U_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_u_state <= U_IDLE;
    else     r_u_state <= w_u_next;
  end

  always_comb begin
    w_u_next = r_u_state;
    case (r_u_state)
      U_IDLE:  if (w_load) w_u_next = U_START;
      U_START: if (w_bit_end) w_u_next = U_DATA;
      U_DATA:  if (w_bit_end && r_u_bits == 4'(UART_BITS - 2)) w_u_next = U_STOP;
      U_STOP:  if (w_bit_end) w_u_next = U_IDLE;
      default: w_u_next = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud     <= '0;
      r_u_bits   <= '0;
      r_tx_shift <= '0;
    end else if (w_load) begin
      r_baud     <= '0;
      r_u_bits   <= '0;
      r_tx_shift <= w_rx_data;
    end else if (r_u_state != U_IDLE) begin
      if (w_bit_end) begin
        r_baud   <= '0;
        r_u_bits <= r_u_bits + 4'd1;
        if (r_u_state == U_DATA) r_tx_shift <= {1'b0, r_tx_shift[7:1]};
      end else begin
        r_baud <= r_baud + BAUD_W'(1);
      end
    end
  end

  always_comb begin
    case (r_u_state)
      U_START: w_tx = 1'b0;
      U_DATA:  w_tx = r_tx_shift[0];
      default: w_tx = 1'b1;
    endcase
  end

  always_comb begin
    uo_out           = 8'h00;
    uo_out[UO_VALID] = r_valid;
    uo_out[UO_INT]   = r_int;
    uo_out[UO_RDY]   = ~w_empty;
    uo_out[UO_FULL]  = w_full;
    uo_out[UO_TX]    = w_tx;
    uio_out          = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    uio_oe           = r_cs_sync ? 8'hFF : 8'h00;
  end

endmodule

// File: tb/tb_ps2_decoder.sv
// Directed bench for ps2_decoder: framing table, FIFO fill/drain, interrupt,
// receiver timeout, UART echo waveform and asynchronous reset.
module tb_ps2_decoder;

  localparam int HALF    = 20;
  localparam int CPB     = 10_000_000 / 115200;
  localparam int TIMEOUT = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       ps2_clk = 1'b1, ps2_data = 1'b1, clr = 1'b0, cs = 1'b0;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

  assign ui_in  = {4'b0000, cs, clr, ps2_data, ps2_clk};
  assign uio_in = 8'h00;

  always #5 clk = ~clk;

  ps2_decoder dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         tx_fall_cyc = -1;
  int         tx_rise_cyc = -1;
  logic       tx_prev = 1'b1;
  logic       int_seen = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       start;
    logic       stop;
    logic       exp_valid;
  } vec_t;
  vec_t vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_prev && !uo_out[4]) tx_fall_cyc = cyc;
    if (!tx_prev && uo_out[4]) tx_rise_cyc = cyc;
    tx_prev = uo_out[4];
    if (uo_out[1]) int_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic st, input logic sp);
    send_bits({sp, p, d, st}, 11);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, ~^d, 1'b0, 1'b1);
    if (exp_q.size() < 8) exp_q.push_back(d);
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic host_read();
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    cs = 1'b1;
    repeat (4) @(negedge clk);
    check("oe_cs_high", uio_oe, 8'hFF);
    check("read_data", uio_out, e);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check("oe_cs_low", uio_oe, 8'h00);
    check("data_rdy_after_read", uo_out[2], exp_q.size() != 0);
    check("full_after_read", uo_out[3], exp_q.size() == 8);
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'h1C, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{8'h7E, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset
    repeat (3) @(negedge clk);
    check("reset_uo_out", uo_out, 8'h10);
    check("reset_uio_oe", uio_oe, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_reset_uo_out", uo_out, 8'h10);

    // Framing table
    for (int i = 0; i < 8; i++) begin
      pulse_clear();
      send_frame(vecs[i].data, vecs[i].par, vecs[i].start, vecs[i].stop);
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
      check("vec_valid", uo_out[0], vecs[i].exp_valid);
      check("vec_interrupt", uo_out[1], vecs[i].exp_valid);
      check("vec_data_rdy", uo_out[2], vecs[i].exp_valid);
      host_read();
    end

    // FIFO fill and overflow drop
    pulse_clear();
    for (int i = 1; i <= 8; i++) send_good(8'(i));
    check("fill_full", uo_out[3], 1'b1);
    check("fill_rdy", uo_out[2], 1'b1);
    pulse_clear();
    send_good(8'h09);
    check("overflow_full", uo_out[3], 1'b1);
    check("overflow_no_int", uo_out[1], 1'b0);
    check("overflow_head", uio_out, 8'h01);
    for (int i = 0; i < 8; i++) host_read();
    check("drain_rdy", uo_out[2], 1'b0);
    check("drain_full", uo_out[3], 1'b0);

    // Interrupt clear, and set winning over a held clear
    send_good(8'h33);
    check("int_set", uo_out[1], 1'b1);
    pulse_clear();
    check("int_cleared", uo_out[1], 1'b0);
    host_read();
    clr = 1'b1;
    repeat (4) @(negedge clk);
    int_seen = 1'b0;
    send_good(8'h44);
    check("int_seen_under_clear", int_seen, 1'b1);
    check("int_low_after_clear", uo_out[1], 1'b0);
    clr = 1'b0;
    host_read();

    // Receiver timeout discards a partial frame
    send_bits(11'b000_0000_1010, 4);
    repeat (TIMEOUT + 100) @(negedge clk);
    check("timeout_valid_kept", uo_out[0], 1'b1);
    check("timeout_no_data", uo_out[2], 1'b0);
    send_good(8'h5A);
    check("post_timeout_valid", uo_out[0], 1'b1);
    host_read();

    // UART echo of 0xF0
    repeat (1000) @(negedge clk);
    check("tx_idle", uo_out[4], 1'b1);
    tx_fall_cyc = -1;
    tx_rise_cyc = -1;
    send_good(8'hF0);
    check("tx_started", tx_fall_cyc != -1, 1'b1);
    begin
      logic [9:0] exp_bits;
      int         target;
      exp_bits = {1'b1, 8'hF0, 1'b0};
      for (int i = 0; i < 10; i++) begin
        target = tx_fall_cyc + CPB / 2 + i * CPB;
        while (cyc < target) @(negedge clk);
        check("tx_bit", uo_out[4], exp_bits[i]);
      end
    end
    check("tx_low_len_ok", (tx_rise_cyc - tx_fall_cyc >= 5 * CPB - 5) &&
                           (tx_rise_cyc - tx_fall_cyc <= 5 * CPB + 5), 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("tx_idle_after", uo_out[4], 1'b1);
    host_read();

    // Asynchronous reset in the middle of a UART frame
    send_good(8'h81);
    repeat (100) @(negedge clk);
    check("tx_busy_before_reset", (uo_out[4] == 1'b0) || (tx_fall_cyc != -1), 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_reset_uo_out", uo_out, 8'h10);
    check("async_reset_uio_out", uio_out, 8'h00);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("after_reset_tx", uo_out[4], 1'b1);
    check("after_reset_rdy", uo_out[2], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_decoder.md
Name: ps2_decoder

Overview:
PS/2 keyboard receiver for a 68000-style host, wrapped in the Tiny Tapeout pin convention.
- Deserialises PS/2 frames and checks framing and parity.
- Pushes good scancodes into an 8-deep FIFO, which the host reads over the bidirectional bus using a chip select.
- Raises an interrupt when a byte arrives.
- Echoes every good byte on an 8N1 UART TX line.
- Sits directly under the chip top level. The top level inverts the pad rst_n into rst and ties off power pins.

Parameters:
CLK_HZ, 10_000_000, system clock frequency.
BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated.
FIFO_DEPTH, 8, scancode FIFO entries. Must be a power of 2.
TIMEOUT_CYCLES, 20000, idle clocks mid-frame before the PS/2 receiver abandons the frame.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
ena  in  1  design-selected flag. Ignored; logic always runs.
ui_in  in  8  bit 0 ps2_clk, bit 1 ps2_data, bit 2 clear_int, bit 3 cs (active high). Bits 7:4 unused.
uio_in  in  8  unused.
uo_out  out  8  bit 0 valid, bit 1 interrupt, bit 2 data_rdy, bit 3 fifo_full, bit 4 uart_tx. Bits 7:5 = 0.
uio_out  out  8  FIFO head byte.
uio_oe  out  8  0xFF while cs=1, else 0x00.

Behaviour:
- Reset values (async, immediate): valid=0, interrupt=0, data_rdy=0, fifo_full=0, uart_tx=1, uio_out=0x00, uio_oe=0x00. FIFO emptied; receiver and UART return to idle.
- Synchronisers: ps2_clk, ps2_data, clear_int and cs each pass through a 2-FF synchroniser. Edge detection uses the synchronised signals.
- PS/2 receive:
  - Data is sampled on each synchronised ps2_clk falling edge.
  - Frame is 11 bits: start(0), D0..D7 LSB first, odd parity, stop(1).
  - A frame is good when start=0, stop=1, and the count of ones over D0..D7 plus the parity bit is odd.
  - After the stop bit:
    - Good frame: valid<=1 and a FIFO push is requested.
    - Bad frame: valid<=0, no push.
  - valid is a level that holds until the next completed frame.
  - Timeout: TIMEOUT_CYCLES clocks with no falling edge while partway through a frame discards the partial frame and returns the receiver to waiting for start. valid is unchanged.
- FIFO:
  - Push writes at the tail. A push while full drops the byte, and FIFO contents are unchanged.
  - data_rdy = not empty. fifo_full = count==FIFO_DEPTH.
  - uio_out always shows the head entry, or 0x00 when empty.
  - Pop occurs on the synchronised cs falling edge (end of a host read), only if not empty.
  - A push and a pop in the same cycle are both performed, and the count is unchanged.
- Interrupt:
  - Set the cycle a good byte is pushed.
  - Cleared while synchronised clear_int=1.
  - If set and clear happen in the same cycle, set wins.
  - A dropped push (FIFO full) does not set it.
- UART:
  - Each good frame's byte is loaded into the transmitter if it is idle. If it is busy, the byte is not sent (FIFO storage is unaffected).
  - Frame: start 0, D0..D7 LSB first, stop 1, each bit CLKS_PER_BIT clocks. Idle line is 1.
  - Transmission begins within 2 clocks of valid rising or refreshing.
- Reset mid-frame or mid-UART: everything aborts immediately; uart_tx returns to 1.

Decomposition:
- Package ps2_decoder_pkg: frame bit-count constant (11), UART bit count (10), receiver state enum {IDLE, DATA, PARITY, STOP}, UART state enum {U_IDLE, U_START, U_DATA, U_STOP}, uo_out bit-index constants.
- One sub-module, ps2_rx_frame: synchronisers, edge detect, shift register, parity/stop check, timeout. Outputs a byte plus one-cycle good/bad strobes.
- FIFO, interrupt and UART stay in the top block.

Test Plan:
- Reset: hold rst 3 clocks -> uo_out=0x10, uio_oe=0x00, uio_out=0x00.
- Frame 0x1C with parity 0 -> valid=1, interrupt=1, data_rdy=1. Pulse cs 1→0: during cs=1, uio_oe=0xFF and uio_out=0x1C; after the fall, data_rdy=0.
- Frame 0x1C with parity 1 (bad) -> valid=0, data_rdy stays 0, interrupt stays 0.
- Send 9 frames, bytes 0x01..0x09:
  - After the 8th, fifo_full=1.
  - Eight cs reads return 0x01..0x08 in order; 0x09 is dropped.
  - After the last read, data_rdy=0 and fifo_full=0.
- Good frame then clear_int=1 for 3 clocks -> interrupt=0. Also check clear_int held high across a push: interrupt=1 that cycle.
- Frame 0xF0 with parity 1 -> uart_tx shows 0, 0, 0, 0, 0, 1, 1, 1, 1, 1: start bit, then 0xF0 LSB first, then stop. Each bit lasts CLKS_PER_BIT±1 clocks. Idle 1 afterwards.
